ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port InstrD, input, 32 bits: the decode-stage instruction word.
REQ-004 The block SHALL have the port ALUFlags, input, 4 bits: execute-stage flags, ordered {N,Z,C,V}.
REQ-005 The block SHALL have the port FlushE, input, 1 bit: clears the execute control register.
REQ-006 The block SHALL have the following decode outputs, each combinational from InstrD:
- RegSrcD, 2 bits.
- ImmSrcD, 2 bits.
REQ-007 The block SHALL have the following execute outputs:
- AluSrcE, 1 bit.
- AluControlE, 4 bits.
- sh_control, 2 bits.
- shamt, 5 bits.
- BranchTakenE, 1 bit.
- MemtoRegE, 1 bit (hazard use).
REQ-008 The block SHALL have the following memory outputs:
- MemWriteM, 1 bit.
- RegWriteM, 1 bit.
REQ-009 The block SHALL have the following write-back outputs:
- RegWriteW, 1 bit.
- MemtoRegW, 1 bit.
- PCSrcW, 1 bit.
- WA3_mux, 1 bit.
- WD3_mux, 1 bit.

Function
REQ-010 The decode op field InstrD[27:26] SHALL select the instruction class: 00 is data-processing (DP), 01 is memory, 10 is branch, and 11 is undefined, which behaves as a NOP.
REQ-011 The DP command field InstrD[24:21] SHALL be limited to:
- AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101, CMP 1010.
- CMP SHALL set RegWrite=0.
- AluControl SHALL equal the command field, except CMP, which SHALL use 0010.
REQ-012 For DP with InstrD[25]=1, the block SHALL drive:
- AluSrc=1, ImmSrc=00.
- sh_control=11, shamt={InstrD[11:8],1'b0}.
REQ-013 For DP with InstrD[25]=0, the block SHALL drive AluSrc=0, sh_control=InstrD[6:5] and shamt=InstrD[11:7].
REQ-014 Memory instructions SHALL decode as follows:
- AluSrc=1, ImmSrc=01, AluControl=0100, sh_control=00, shamt=0.
- L=InstrD[20]=1 gives MemtoReg=1 and RegWrite=1.
- L=0 gives MemWrite=1 and RegSrc[1]=1.
REQ-015 Branch instructions SHALL decode as follows:
- RegSrc[0]=1, ImmSrc=10, AluSrc=1, AluControl=0100, shamt=0, Branch=1.
- InstrD[24]=1 SHALL mark Link.
REQ-016 FlagWrite SHALL equal InstrD[20] for DP, and SHALL be forced to 1 for CMP.
REQ-017 The decode-to-execute register SHALL capture all decoded controls plus cond=InstrD[31:28] every cycle.
REQ-018 Condition evaluation SHALL occur in execute against the internal flag register (not ALUFlags). Supported codes are EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL; 1111 SHALL evaluate false.
REQ-019 CondExE SHALL gate RegWrite, MemWrite, FlagWrite, Branch and Link before they leave execute.
REQ-020 The flag register SHALL load ALUFlags at the clock edge when FlagWriteE & CondExE are both 1.
REQ-021 BranchTakenE SHALL equal BranchE & CondExE, combinationally in the same cycle.
REQ-022 PCSrc SHALL be 1 when RegWrite is 1 and Rd=15. It SHALL be gated by CondExE and piped to W.
REQ-023 The execute-to-memory and memory-to-write-back registers SHALL carry controls unconditionally, one cycle per stage; latency from decode to W is 3 clocks.
REQ-024 FlushE=1 SHALL load the decode-to-execute register with all-zero controls (a NOP) and cond=1110. The flag register SHALL NOT be affected by FlushE.
REQ-025 When the flag update and the condition read occur in the same cycle, the condition SHALL use the old flags; the new flags SHALL be visible from the next cycle.

Reset
REQ-026 Reset SHALL clear all pipeline control registers, the flag register, and every registered output to 0.
REQ-027 Reset asserted mid-instruction SHALL discard all in-flight controls; no write SHALL occur in the cycle after reset deasserts.

Configuration
REQ-028 With the macro CTRL_BL_LINK_EN defined, a taken Link branch SHALL:
- set RegWrite=1 in W;
- drive WA3_mux=1 and WD3_mux=1 in W.
REQ-029 Without CTRL_BL_LINK_EN, Link SHALL be ignored: BL behaves as B, and WA3_mux and WD3_mux SHALL be tied to 0.

Structure
REQ-030 A shared package ctrl_pkg SHALL hold:
- the op-class, ALU-command and condition-code constants;
- the ImmSrc and sh_control encodings;
- the typedef of the packed control bundle used by all pipeline registers.
REQ-031 The block SHALL contain one sub-module, cond_unit: combinational, taking cond[3:0] and flags[3:0] and producing CondEx.

Verification
REQ-032 The bench SHALL check: after reset, a data-processing ADD (0xE0812002) with ALUFlags=0 -> AluControlE=0100 and AluSrcE=0 one cycle later; RegWriteW=1 three cycles after decode.
REQ-033 The bench SHALL check: CMP setting Z=1, followed by BEQ (0x0A000002) -> BranchTakenE=1 in BEQ's execute cycle; the same sequence with Z=0 -> BranchTakenE=0.
REQ-034 The bench SHALL check: STR (0xE5812000) -> RegSrcD=10 and ImmSrcD=01 in decode, MemWriteM=1 two cycles later, and RegWriteW=0.
REQ-035 The bench SHALL check: FlushE=1 while an ADD is in decode -> all E/M/W controls stay 0 for that instruction; flags unchanged.
REQ-036 The bench SHALL check: BL (0xEB000004) with CTRL_BL_LINK_EN defined -> WA3_mux=WD3_mux=RegWriteW=1 in W; without the macro, all three = 0.
REQ-037 The bench SHALL check: MOV PC,R1 (0xE1A0F001) -> PCSrcW=1 three cycles after decode.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and control bundles for the ctrl_pipeline slice.
// CTRL_BL_LINK_EN adds the link bit to the bundles that carry it.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Decode-to-execute bundle
  typedef struct packed {
    logic [3:0] cond;
    logic       reg_write;
    logic       mem_write;
    logic       memto_reg;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [1:0] sh_control;
    logic [4:0] shamt;
    logic       flag_write;
    logic       branch;
    logic       pc_src;
`ifdef CTRL_BL_LINK_EN
    logic       link;
`endif
  } ctrl_t;

  // Execute-to-memory bundle (already condition-gated)
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic memto_reg;
    logic pc_src;
`ifdef CTRL_BL_LINK_EN
    logic link;
`endif
  } mem_ctrl_t;

  // Memory-to-write-back bundle
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic pc_src;
`ifdef CTRL_BL_LINK_EN
    logic link;
`endif
  } wb_ctrl_t;

  // Flushed slot: no controls, condition AL
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c      = '0;
    c.cond = COND_AL;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Instruction/flag inputs and stage control outputs of ctrl_pipeline.
// master drives the decode side; slave is the pipeline itself.
interface ctrl_pipeline_if;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;

  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;

  logic        AluSrcE;
  logic [3:0]  AluControlE;
  logic [1:0]  sh_control;
  logic [4:0]  shamt;
  logic        BranchTakenE;
  logic        MemtoRegE;

  logic        MemWriteM;
  logic        RegWriteM;

  logic        RegWriteW;
  logic        MemtoRegW;
  logic        PCSrcW;
  logic        WA3_mux;
  logic        WD3_mux;

  modport master (
    output InstrD, ALUFlags, FlushE,
    input  RegSrcD, ImmSrcD,
    input  AluSrcE, AluControlE, sh_control, shamt, BranchTakenE, MemtoRegE,
    input  MemWriteM, RegWriteM,
    input  RegWriteW, MemtoRegW, PCSrcW, WA3_mux, WD3_mux
  );

  modport slave (
    input  InstrD, ALUFlags, FlushE,
    output RegSrcD, ImmSrcD,
    output AluSrcE, AluControlE, sh_control, shamt, BranchTakenE, MemtoRegE,
    output MemWriteM, RegWriteM,
    output RegWriteW, MemtoRegW, PCSrcW, WA3_mux, WD3_mux
  );
endinterface

// File: rtl/cond_unit.sv
// Condition-code evaluator: cond against {N,Z,C,V}; 1111 never executes.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// Four-stage control path: decode, condition-gated execute, M and W registers.
// Define CTRL_BL_LINK_EN to make taken BL write the link register in W.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  ctrl_pipeline_if.slave bus
);
  ctrl_t      dec, ctrl_e;
  mem_ctrl_t  mem_nxt, ctrl_m;
  wb_ctrl_t   ctrl_w;
  logic [1:0] reg_src_d, imm_src_d;
  logic [3:0] flags;
  logic       cond_ex;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       unused_instr;

  assign op           = bus.InstrD[27:26];
  assign cmd          = bus.InstrD[24:21];
  assign unused_instr = ^{bus.InstrD[19:16], bus.InstrD[4:0]};

  always_comb begin
    dec       = '0;
    reg_src_d = 2'b00;
    imm_src_d = IMM_DP;
    dec.cond  = bus.InstrD[31:28];
    case (op)
      OP_DP: begin
        dec.alu_src     = bus.InstrD[25];
        dec.reg_write   = (cmd != CMD_CMP);
        dec.flag_write  = bus.InstrD[20] | (cmd == CMD_CMP);
        dec.alu_control = (cmd == CMD_CMP) ? CMD_SUB : cmd;
        if (bus.InstrD[25]) begin
          dec.sh_control = SH_ROR;
          dec.shamt      = {bus.InstrD[11:8], 1'b0};
        end else begin
          dec.sh_control = bus.InstrD[6:5];
          dec.shamt      = bus.InstrD[11:7];
        end
      end
      OP_MEM: begin
        dec.alu_src     = 1'b1;
        dec.alu_control = CMD_ADD;
        imm_src_d       = IMM_MEM;
        if (bus.InstrD[20]) begin
          dec.memto_reg = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.mem_write = 1'b1;
          reg_src_d[1]  = 1'b1;
        end
      end
      OP_BR: begin
        dec.alu_src     = 1'b1;
        dec.alu_control = CMD_ADD;
        dec.branch      = 1'b1;
        imm_src_d       = IMM_BR;
        reg_src_d[0]    = 1'b1;
`ifdef CTRL_BL_LINK_EN
        dec.link        = bus.InstrD[24];
`endif
      end
      default: ;  // undefined class decodes as NOP
    endcase
    dec.pc_src = dec.reg_write & (bus.InstrD[15:12] == 4'hF);
  end

  assign bus.RegSrcD = reg_src_d;
  assign bus.ImmSrcD = imm_src_d;

  // Condition reads the registered flags, so a same-cycle update is not seen
  cond_unit u_cond (
    .cond    (ctrl_e.cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  always_comb begin
    mem_nxt           = '0;
    mem_nxt.reg_write = ctrl_e.reg_write & cond_ex;
    mem_nxt.mem_write = ctrl_e.mem_write & cond_ex;
    mem_nxt.memto_reg = ctrl_e.memto_reg;
    mem_nxt.pc_src    = ctrl_e.pc_src & cond_ex;
`ifdef CTRL_BL_LINK_EN
    mem_nxt.link      = ctrl_e.link & ctrl_e.branch & cond_ex;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
      flags  <= '0;
    end else begin
      ctrl_e           <= bus.FlushE ? ctrl_nop() : dec;
      ctrl_m           <= mem_nxt;
      ctrl_w.reg_write <= ctrl_m.reg_write;
      ctrl_w.memto_reg <= ctrl_m.memto_reg;
      ctrl_w.pc_src    <= ctrl_m.pc_src;
`ifdef CTRL_BL_LINK_EN
      ctrl_w.link      <= ctrl_m.link;
`endif
      if (ctrl_e.flag_write & cond_ex) flags <= bus.ALUFlags;
    end
  end

  assign bus.AluSrcE      = ctrl_e.alu_src;
  assign bus.AluControlE  = ctrl_e.alu_control;
  assign bus.sh_control   = ctrl_e.sh_control;
  assign bus.shamt        = ctrl_e.shamt;
  assign bus.MemtoRegE    = ctrl_e.memto_reg;
  assign bus.BranchTakenE = ctrl_e.branch & cond_ex;

  assign bus.MemWriteM = ctrl_m.mem_write;
  assign bus.RegWriteM = ctrl_m.reg_write;

  assign bus.MemtoRegW = ctrl_w.memto_reg;
  assign bus.PCSrcW    = ctrl_w.pc_src;
`ifdef CTRL_BL_LINK_EN
  assign bus.RegWriteW = ctrl_w.reg_write | ctrl_w.link;
  assign bus.WA3_mux   = ctrl_w.link;
  assign bus.WD3_mux   = ctrl_w.link;
`else
  assign bus.RegWriteW = ctrl_w.reg_write;
  assign bus.WA3_mux   = 1'b0;
  assign bus.WD3_mux   = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: instruction-level reference model,
// directed scenarios followed by a random instruction stream.
module tb_ctrl_pipeline;
`ifdef CTRL_BL_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  localparam logic [31:0] I_NOP   = 32'hEC000000;
  localparam logic [31:0] I_ADD   = 32'hE0812002;
  localparam logic [31:0] I_CMP   = 32'hE1500001;
  localparam logic [31:0] I_CMPEQ = 32'h01500001;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_STR   = 32'hE5812000;
  localparam logic [31:0] I_BL    = 32'hEB000004;
  localparam logic [31:0] I_MOVPC = 32'hE1A0F001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipeline_if bus();
  ctrl_pipeline dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [1:0] rsrc, isrc;
    logic       asrc;
    logic [3:0] actl;
    logic [1:0] sh;
    logic [4:0] sa;
    logic       rw, mw, mtr, fw, br, lnk, pcs;
    logic [3:0] cond;
  } dec_t;

  typedef struct packed { logic rw, mw, mtr, pcs, lnk; } st_t;

  typedef struct packed {
    logic [1:0] rsrc, isrc;
    logic       asrc;
    logic [3:0] actl;
    logic [1:0] sh;
    logic [4:0] sa;
    logic       bte, mtre, mwm, rwm, rww, mtrw, pcsw, wa3, wd3;
  } exp_t;

  exp_t        q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // instruction-level model state
  logic [31:0] prev_instr = I_NOP;
  bit          prev_kill  = 1'b1;
  logic [3:0]  mflags     = 4'b0;
  st_t         g1 = '0, g2 = '0;   // results of the last two instructions to leave execute

  function automatic dec_t ref_dec(logic [31:0] i);
    dec_t d;
    bit   cmp;
    d      = '0;
    d.cond = i[31:28];
    cmp    = (i[24:21] == 4'b1010);
    if (i[27:26] == 2'b00) begin
      d.asrc = i[25];
      d.actl = cmp ? 4'b0010 : i[24:21];
      d.rw   = !cmp;
      d.fw   = i[20] || cmp;
      d.sh   = i[25] ? 2'b11 : i[6:5];
      d.sa   = i[25] ? {i[11:8], 1'b0} : i[11:7];
    end else if (i[27:26] == 2'b01) begin
      d.asrc = 1'b1; d.isrc = 2'b01; d.actl = 4'b0100;
      d.mtr  = i[20]; d.rw = i[20]; d.mw = !i[20];
      d.rsrc = {!i[20], 1'b0};
    end else if (i[27:26] == 2'b10) begin
      d.rsrc = 2'b01; d.isrc = 2'b10; d.asrc = 1'b1; d.actl = 4'b0100;
      d.br   = 1'b1; d.lnk = i[24];
    end
    d.pcs = d.rw && (i[15:12] == 4'd15);
    return d;
  endfunction

  // Even codes test a predicate, odd codes its inverse; 1110 always, 1111 never
  function automatic bit ref_cond(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c == 4'b1110) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(0, 2) == 0) i[31:28] = 4'hE;
    if (i[27:26] == 2'b00) begin
      case ($urandom_range(0, 5))
        0: i[24:21] = 4'b0000;
        1: i[24:21] = 4'b0010;
        2: i[24:21] = 4'b0100;
        3: i[24:21] = 4'b1100;
        4: i[24:21] = 4'b1101;
        default: i[24:21] = 4'b1010;
      endcase
    end
    if ($urandom_range(0, 5) == 0) i[15:12] = 4'hF;
    return i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, push expected outputs for this cycle, advance model
  task automatic issue(input logic [31:0] instr, input logic [3:0] af,
                       input bit fl, input bit rs);
    dec_t d, e;
    bit   ce;
    exp_t x;
    st_t  gn;
    @(posedge clk); #1;
    bus.InstrD = instr; bus.ALUFlags = af; bus.FlushE = fl; reset = rs;
    d = ref_dec(instr);
    if (prev_kill) e = '0; else e = ref_dec(prev_instr);
    ce = ref_cond(e.cond, mflags);
    x.rsrc = d.rsrc; x.isrc = d.isrc;
    x.asrc = e.asrc; x.actl = e.actl; x.sh = e.sh; x.sa = e.sa;
    x.bte  = e.br && ce; x.mtre = e.mtr;
    x.mwm  = g1.mw; x.rwm = g1.rw;
    x.rww  = g2.rw || (LINK_EN && g2.lnk);
    x.mtrw = g2.mtr; x.pcsw = g2.pcs;
    x.wa3  = LINK_EN && g2.lnk; x.wd3 = LINK_EN && g2.lnk;
    q.push_back(x);
    gn.rw = e.rw && ce; gn.mw = e.mw && ce; gn.mtr = e.mtr;
    gn.pcs = e.pcs && ce; gn.lnk = e.lnk && e.br && ce;
    if (rs) begin
      mflags = 4'b0; g1 = '0; g2 = '0; prev_kill = 1'b1;
    end else begin
      if (e.fw && ce) mflags = af;
      g2 = g1; g1 = gn; prev_instr = instr; prev_kill = fl;
    end
    @(negedge clk);
  endtask

  task automatic nop(); issue(I_NOP, 4'b0, 1'b0, 1'b0); endtask

  // Monitor: every cycle the DUT presents a full set of stage controls
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("RegSrcD",      bus.RegSrcD,      x.rsrc);
        chk("ImmSrcD",      bus.ImmSrcD,      x.isrc);
        chk("AluSrcE",      bus.AluSrcE,      x.asrc);
        chk("AluControlE",  bus.AluControlE,  x.actl);
        chk("sh_control",   bus.sh_control,   x.sh);
        chk("shamt",        bus.shamt,        x.sa);
        chk("BranchTakenE", bus.BranchTakenE, x.bte);
        chk("MemtoRegE",    bus.MemtoRegE,    x.mtre);
        chk("MemWriteM",    bus.MemWriteM,    x.mwm);
        chk("RegWriteM",    bus.RegWriteM,    x.rwm);
        chk("RegWriteW",    bus.RegWriteW,    x.rww);
        chk("MemtoRegW",    bus.MemtoRegW,    x.mtrw);
        chk("PCSrcW",       bus.PCSrcW,       x.pcsw);
        chk("WA3_mux",      bus.WA3_mux,      x.wa3);
        chk("WD3_mux",      bus.WD3_mux,      x.wd3);
      end
    end
  end

  initial begin
    reset = 1'b1; bus.InstrD = I_NOP; bus.ALUFlags = 4'b0; bus.FlushE = 1'b0;
    issue(I_NOP, 4'b0, 1'b0, 1'b1);
    issue(I_NOP, 4'b0, 1'b0, 1'b1);
    chk("rst_aluctl_e", bus.AluControlE, 4'b0);
    chk("rst_rw_w",     bus.RegWriteW,   1'b0);

    // ADD straight after reset
    issue(I_ADD, 4'b0, 1'b0, 1'b0);
    nop(); chk("add_aluctl_e", bus.AluControlE, 4'b0100);
           chk("add_alusrc_e", bus.AluSrcE, 1'b0);
    nop();
    nop(); chk("add_rw_w", bus.RegWriteW, 1'b1);

    // CMP then BEQ, Z set / clear
    issue(I_CMP, 4'b0, 1'b0, 1'b0);
    issue(I_BEQ, 4'b0100, 1'b0, 1'b0);
    nop(); chk("beq_taken", bus.BranchTakenE, 1'b1);
    issue(I_CMP, 4'b0, 1'b0, 1'b0);
    issue(I_BEQ, 4'b0000, 1'b0, 1'b0);
    nop(); chk("beq_not_taken", bus.BranchTakenE, 1'b0);

    // CMPEQ evaluates against old Z=1 while clearing Z
    issue(I_CMP, 4'b0, 1'b0, 1'b0);
    issue(I_CMPEQ, 4'b0100, 1'b0, 1'b0);
    issue(I_BEQ, 4'b0000, 1'b0, 1'b0);
    nop(); chk("old_flags_beq", bus.BranchTakenE, 1'b0);

    // STR
    issue(I_STR, 4'b0, 1'b0, 1'b0);
    chk("str_regsrc_d", bus.RegSrcD, 2'b10);
    chk("str_immsrc_d", bus.ImmSrcD, 2'b01);
    nop();
    nop(); chk("str_mw_m", bus.MemWriteM, 1'b1);
    nop(); chk("str_rw_w", bus.RegWriteW, 1'b0);

    // Flushed ADD, then flushed CMP must not touch flags
    issue(I_ADD, 4'b0, 1'b1, 1'b0);
    nop(); chk("flush_aluctl_e", bus.AluControlE, 4'b0);
    nop(); chk("flush_rw_m", bus.RegWriteM, 1'b0);
    nop(); chk("flush_rw_w", bus.RegWriteW, 1'b0);
    issue(I_CMP, 4'b0, 1'b1, 1'b0);
    issue(I_BEQ, 4'b0100, 1'b0, 1'b0);
    nop(); chk("flush_flags_kept", bus.BranchTakenE, 1'b0);

    // BL
    issue(I_BL, 4'b0, 1'b0, 1'b0);
    nop(); nop();
    nop(); chk("bl_wa3_w", bus.WA3_mux,   LINK_EN);
           chk("bl_wd3_w", bus.WD3_mux,   LINK_EN);
           chk("bl_rw_w",  bus.RegWriteW, LINK_EN);

    // MOV PC,R1
    issue(I_MOVPC, 4'b0, 1'b0, 1'b0);
    nop(); nop();
    nop(); chk("movpc_pcsrc_w", bus.PCSrcW, 1'b1);

    // Reset while ADD is in execute
    issue(I_ADD, 4'b0, 1'b0, 1'b0);
    issue(I_NOP, 4'b0, 1'b0, 1'b1);
    nop(); chk("rst_mid_rw_m", bus.RegWriteM, 1'b0);
    nop(); chk("rst_mid_rw_w", bus.RegWriteW, 1'b0);

    // Random stream
    for (int k = 0; k < 2000; k++)
      issue(rnd_instr(), 4'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 99) == 0));
    for (int k = 0; k < 4; k++) nop();

    @(posedge clk); @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
